as_test_monitor: RTL and testbench

//  Synthesisable self-test result monitor for as_top_mem-based SoCs; replaces per-bench GPIO checking.
//  - Samples the firmware status port (gpio + chip-select strobe).
//  - Decodes step, pass and fail codes, and counts progress steps.
//  - Runs an inactivity watchdog.
//  - Exposes sticky verdict flags usable by benches, FPGA LEDs or a debug CSR.

---
 rtl/as_test_monitor.sv | 116 +++++++++++
 tb/tb_as_test_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/as_test_monitor.sv
// as_test_monitor: firmware self-test status monitor.
// Samples the cs/gpio status port, decodes step/pass/fail codes, counts steps,
// runs an inactivity watchdog and holds sticky pass/fail verdict flags.
// Optional build macro AS_TEST_MON_ORDER_EN: step codes must arrive as 1,2,3...
module as_test_monitor #(
   parameter int unsigned GPIO_W      = 8,
   parameter int unsigned PASS_CODE   = 7,
   parameter int unsigned TIMEOUT_CYC = 100000,
   parameter int unsigned STEP_W      = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cs_i,
   input  logic [GPIO_W-1:0] gpio_i,
   input  logic              clear_i,
   output logic [1:0]        state_o,
   output logic              pass_o,
   output logic              fail_o,
   output logic [1:0]        err_cause_o,
   output logic [STEP_W-1:0] step_cnt_o,
   output logic [GPIO_W-1:0] last_code_o
);

   // A zero timeout disables the watchdog; keep a 1-bit counter so widths stay legal.
   localparam int unsigned WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam bit          WD_EN = (TIMEOUT_CYC != 0);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] CAUSE_BAD     = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
   localparam logic [1:0] CAUSE_ORDER   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_PASS = 2'd2,
      S_FAIL = 2'd3
   } state_t;

   state_t          state;
   logic            cs_q;
   logic [WD_W-1:0] wd;

   logic ev;
   logic is_pass;
   logic is_step;
   logic order_ok;
   logic step_sat;
   logic active;

   // Rising edge of the chip-select is one status event.
   assign ev       = cs_i & ~cs_q;
   assign is_pass  = (gpio_i == GPIO_W'(PASS_CODE));
   assign is_step  = (gpio_i != '0) && (gpio_i < GPIO_W'(PASS_CODE));
   assign step_sat = &step_cnt_o;
   assign active   = (state == S_IDLE) || (state == S_RUN);

`ifdef AS_TEST_MON_ORDER_EN
   // Steps must be the next number in sequence after the current count.
   assign order_ok = (32'(gpio_i) == (32'(step_cnt_o) + 32'd1));
`else
   assign order_ok = 1'b1;
`endif

   assign state_o = state;

   // Monitor FSM with registered verdict, counter and code outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= S_IDLE;
         cs_q        <= 1'b0;
         wd          <= '0;
         pass_o      <= 1'b0;
         fail_o      <= 1'b0;
         err_cause_o <= 2'd0;
         step_cnt_o  <= '0;
         last_code_o <= '0;
      end else begin
         cs_q <= cs_i;
         if (clear_i) begin
            state       <= S_IDLE;
            wd          <= '0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            err_cause_o <= 2'd0;
            step_cnt_o  <= '0;
            last_code_o <= '0;
         end else if (ev && active) begin
            last_code_o <= gpio_i;
            wd          <= '0;
            if (is_pass) begin
               state  <= S_PASS;
               pass_o <= 1'b1;
            end else if (is_step && order_ok) begin
               state <= S_RUN;
               if (!step_sat) begin
                  step_cnt_o <= step_cnt_o + 1'b1;
               end
            end else begin
               state       <= S_FAIL;
               fail_o      <= 1'b1;
               err_cause_o <= is_step ? CAUSE_ORDER : CAUSE_BAD;
            end
         end else if (WD_EN && (state == S_RUN)) begin
            if (wd == WD_LAST) begin
               state       <= S_FAIL;
               fail_o      <= 1'b1;
               err_cause_o <= CAUSE_TIMEOUT;
            end else begin
               wd <= wd + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_as_test_monitor.sv
// Bench for as_test_monitor: two instances (wide and 2-bit step counter) share
// the stimulus and are compared every cycle against a behavioural model.
module tb_as_test_monitor;

   localparam int unsigned TO = 50;
`ifdef AS_TEST_MON_ORDER_EN
   localparam bit ORDER = 1'b1;
`else
   localparam bit ORDER = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cs = 1'b0;
   logic [7:0] gpio = 8'd0;
   logic       clear = 1'b0;

   logic [1:0] st_a, ca_a, st_b, ca_b;
   logic       ps_a, fl_a, ps_b, fl_b;
   logic [7:0] sc_a, lc_a, lc_b;
   logic [1:0] sc_b;

   as_test_monitor #(.GPIO_W(8), .PASS_CODE(7), .TIMEOUT_CYC(TO), .STEP_W(8)) dut_a (
      .clk_i(clk), .rst_i(rst), .cs_i(cs), .gpio_i(gpio), .clear_i(clear),
      .state_o(st_a), .pass_o(ps_a), .fail_o(fl_a), .err_cause_o(ca_a),
      .step_cnt_o(sc_a), .last_code_o(lc_a));

   as_test_monitor #(.GPIO_W(8), .PASS_CODE(7), .TIMEOUT_CYC(TO), .STEP_W(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .cs_i(cs), .gpio_i(gpio), .clear_i(clear),
      .state_o(st_b), .pass_o(ps_b), .fail_o(fl_b), .err_cause_o(ca_b),
      .step_cnt_o(sc_b), .last_code_o(lc_b));

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail = 0;

   // Reference model: 0 idle, 1 run, 2 pass, 3 fail.
   int m_st[2], m_pass[2], m_fail[2], m_cause[2], m_step[2], m_last[2], m_idle[2];
   int m_csq;
   int step_max[2] = '{255, 3};

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_cause[i] = 0;
         m_step[i] = 0; m_last[i] = 0; m_idle[i] = 0;
      end
      m_csq = 0;
   endfunction

   function automatic void model_step();
      bit ev;
      int g;
      bit stepc;
      ev = cs && (m_csq == 0);
      g  = int'(gpio);
      stepc = (g >= 1) && (g <= 6);
      for (int i = 0; i < 2; i++) begin
         if (clear) begin
            m_st[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_cause[i] = 0;
            m_step[i] = 0; m_last[i] = 0; m_idle[i] = 0;
         end else if (ev && m_st[i] <= 1) begin
            m_last[i] = g;
            m_idle[i] = 0;
            if (g == 7) begin
               m_st[i] = 2; m_pass[i] = 1;
            end else if (stepc && (!ORDER || g == m_step[i] + 1)) begin
               m_st[i] = 1;
               if (m_step[i] < step_max[i]) m_step[i]++;
            end else begin
               m_st[i] = 3; m_fail[i] = 1; m_cause[i] = stepc ? 3 : 1;
            end
         end else if (m_st[i] == 1) begin
            m_idle[i]++;
            if (m_idle[i] == TO) begin
               m_st[i] = 3; m_fail[i] = 1; m_cause[i] = 2;
            end
         end
      end
      m_csq = cs ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("a.state", 32'(st_a), m_st[0]);
      chk("a.pass",  32'(ps_a), m_pass[0]);
      chk("a.fail",  32'(fl_a), m_fail[0]);
      chk("a.cause", 32'(ca_a), m_cause[0]);
      chk("a.step",  32'(sc_a), m_step[0]);
      chk("a.last",  32'(lc_a), m_last[0]);
      chk("a.excl",  32'(ps_a & fl_a), 0);
      chk("b.state", 32'(st_b), m_st[1]);
      chk("b.pass",  32'(ps_b), m_pass[1]);
      chk("b.fail",  32'(fl_b), m_fail[1]);
      chk("b.cause", 32'(ca_b), m_cause[1]);
      chk("b.step",  32'(sc_b), m_step[1]);
      chk("b.last",  32'(lc_b), m_last[1]);
      chk("b.excl",  32'(ps_b & fl_b), 0);
   endtask

   // One clock: model sees the same inputs the DUT samples, then compare.
   task automatic tick();
      if (!rst) model_reset();
      else model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic pulse(input logic [7:0] code);
      cs = 1'b1; gpio = code; tick();
      cs = 1'b0; tick();
   endtask

   task automatic do_clear();
      clear = 1'b1; tick();
      clear = 1'b0;
   endtask

   initial begin
      int code, r, hold, gap;
      bit doclr;

      // Reset is asynchronous: outputs are zero before any clock edge.
      model_reset();
      #3;
      check_all();
      tick();
      rst = 1'b1;
      tick();

      // Step then pass.
      pulse(8'd1);
      pulse(8'd7);
      chk("t1.step", 32'(sc_a), 1);
      chk("t1.state", 32'(st_a), 2);
      chk("t1.pass", 32'(ps_a), 1);
      chk("t1.last", 32'(lc_a), 7);

      // Bad code fails; a later pass code is ignored.
      do_clear();
      pulse(8'd1);
      cs = 1'b1; gpio = 8'd9; tick();
      chk("t2.state", 32'(st_a), 3);
      chk("t2.cause", 32'(ca_a), 1);
      cs = 1'b0; tick();
      pulse(8'd7);
      chk("t2.ignored.last", 32'(lc_a), 9);
      chk("t2.ignored.pass", 32'(ps_a), 0);

      // Watchdog expires exactly TO cycles after the last event.
      do_clear();
      cs = 1'b1; gpio = 8'd1; tick();
      cs = 1'b0;
      for (int i = 1; i < TO; i++) tick();
      chk("t3.pre_expiry", 32'(st_a), 1);
      tick();
      chk("t3.expired.fail", 32'(fl_a), 1);
      chk("t3.expired.cause", 32'(ca_a), 2);
      chk("t3.expired.last", 32'(lc_a), 1);

      // An event on the expiry cycle wins.
      do_clear();
      cs = 1'b1; gpio = 8'd1; tick();
      cs = 1'b0;
      for (int i = 1; i < TO; i++) tick();
      cs = 1'b1; gpio = 8'd2; tick();
      chk("t3.race.state", 32'(st_a), 1);
      chk("t3.race.step", 32'(sc_a), 2);
      cs = 1'b0; tick();

      // Held chip-select counts once; clear during the hold is not recounted.
      do_clear();
      cs = 1'b1; gpio = 8'd1;
      for (int i = 0; i < 20; i++) tick();
      chk("t4.hold.step", 32'(sc_a), 1);
      do_clear();
      for (int i = 0; i < 5; i++) tick();
      chk("t4.clear.state", 32'(st_a), 0);
      chk("t4.clear.step", 32'(sc_a), 0);
      cs = 1'b0; tick();

      // Step counter saturation / ordering.
      do_clear();
      if (ORDER) begin
         pulse(8'd1); pulse(8'd2); pulse(8'd2);
         chk("t5.order.fail", 32'(fl_a), 1);
         chk("t5.order.cause", 32'(ca_a), 3);
         chk("t5.order.step", 32'(sc_a), 2);
      end else begin
         for (int i = 0; i < 5; i++) pulse(8'd1);
         chk("t5.sat.step", 32'(sc_b), 3);
         chk("t5.sat.state", 32'(st_b), 1);
      end

      // Asynchronous reset mid-run, then restart.
      do_clear();
      pulse(8'd1); pulse(8'd2); pulse(8'd3); pulse(8'd4);
      chk("t6.step", 32'(sc_a), 4);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("t6.async.state", 32'(st_a), 0);
      tick();
      rst = 1'b1;
      tick();
      pulse(8'd1);
      chk("t6.rerun.state", 32'(st_a), 1);
      chk("t6.rerun.step", 32'(sc_a), 1);

      // Randomized transactions, biased towards legal step sequences.
      for (int t = 0; t < 400; t++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0)      code = 0;
         else if (r == 1) code = int'($urandom_range(8, 255));
         else if (r == 2) code = 7;
         else if (r < 10) code = int'($urandom_range(1, 6));
         else             code = (m_step[0] + 1 <= 6) ? m_step[0] + 1 : 1;
         doclr = (m_st[0] >= 2) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 24) == 0);
         hold = int'($urandom_range(1, 3));
         gap  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(45, 55)) : int'($urandom_range(1, 4));
         cs = 1'b1; gpio = 8'(code); clear = doclr;
         tick();
         clear = 1'b0;
         for (int h = 1; h < hold; h++) tick();
         cs = 1'b0;
         for (int g = 0; g < gap; g++) tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
